// File: rtl/ls_access_ctrl.sv
// rtl/ls_access_ctrl.sv - load/store sequencer for the 8-bit data memory, little-endian byte splitting, store-once guard.
// Optional misalignment check: define LSU_MISALIGN_CHK_EN.
module ls_access_ctrl #(
  parameter int AW  = 8,
  parameter int PCW = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req,
  input  logic           is_store,
  input  logic           is_half,
  input  logic [AW-1:0]  addr,
  input  logic [15:0]    wdata,
  input  logic [PCW-1:0] prog_ctr,
  output logic           ready,
  output logic           done,
  output logic [15:0]    rdata,
  output logic           dup,
  output logic           err,
  output logic [AW-1:0]  dm_addr,
  output logic           dm_wr_en,
  output logic [7:0]     dm_dat_in,
  input  logic [7:0]     dm_dat_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]     state;
  logic           store_q;
  logic           half_q;
  logic [AW-1:0]  addr_q;
  logic [15:0]    wdata_q;
  logic [PCW-1:0] last_pc;
  logic           last_pc_vld;
  logic           accept;
  logic           dup_hit;
  logic           misalign;

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;
  assign misalign = is_half && addr[0];
  assign err      = err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  assign ready   = (state == S_IDLE);
  assign accept  = req && ready;
  assign dup_hit = is_store && last_pc_vld && (prog_ctr == last_pc);

  // Memory-side signals are registered one cycle ahead of the access state,
  // so dm_wr_en never depends combinationally on req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      store_q     <= 1'b0;
      half_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_pc     <= '0;
      last_pc_vld <= 1'b0;
      done        <= 1'b0;
      dup         <= 1'b0;
      rdata       <= '0;
      dm_addr     <= '0;
      dm_wr_en    <= 1'b0;
      dm_dat_in   <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            store_q <= is_store;
            half_q  <= is_half;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (is_store) begin
              last_pc     <= prog_ctr;
              last_pc_vld <= 1'b1;
            end
            if (dup_hit) begin
              state <= S_FIN;
              done  <= 1'b1;
              dup   <= 1'b1;
            end else if (misalign) begin
              state <= S_FIN;
              done  <= 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
              err_q <= 1'b1;
`endif
            end else begin
              state    <= S_ACC0;
              dm_addr  <= addr;
              dm_wr_en <= is_store;
              if (is_store) dm_dat_in <= wdata[7:0];
            end
          end
        end
        S_ACC0: begin
          if (!store_q) begin
            if (half_q) rdata[7:0] <= dm_dat_out;
            else        rdata      <= {8'h00, dm_dat_out};
          end
          if (half_q) begin
            state    <= S_ACC1;
            dm_addr  <= addr_q + AW'(1);
            dm_wr_en <= store_q;
            if (store_q) dm_dat_in <= wdata_q[15:8];
          end else begin
            state    <= S_FIN;
            dm_wr_en <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_ACC1: begin
          if (!store_q) rdata[15:8] <= dm_dat_out;
          state    <= S_FIN;
          dm_wr_en <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          dup      <= 1'b0;
          dm_wr_en <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
          err_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls_access_ctrl.sv
// tb/tb_ls_access_ctrl.sv - directed self-checking bench for ls_access_ctrl with a byte memory model.
module tb_ls_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        is_store;
  logic        is_half;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [11:0] prog_ctr;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        dup;
  logic        err;
  logic [7:0]  dm_addr;
  logic        dm_wr_en;
  logic [7:0]  dm_dat_in;
  logic [7:0]  dm_dat_out;

  logic [7:0]  mem [256];
  logic [7:0]  wr_addr_log [256];
  logic [7:0]  wr_data_log [256];
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ls_access_ctrl #(.AW(8), .PCW(12)) dut (
    .clk(clk), .reset(reset), .req(req), .is_store(is_store), .is_half(is_half),
    .addr(addr), .wdata(wdata), .prog_ctr(prog_ctr), .ready(ready), .done(done),
    .rdata(rdata), .dup(dup), .err(err), .dm_addr(dm_addr), .dm_wr_en(dm_wr_en),
    .dm_dat_in(dm_dat_in), .dm_dat_out(dm_dat_out)
  );

  assign dm_dat_out = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en) begin
      mem[dm_addr]                <= dm_dat_in;
      wr_addr_log[wr_cnt[7:0]]    <= dm_addr;
      wr_data_log[wr_cnt[7:0]]    <= dm_dat_in;
      wr_cnt                      <= wr_cnt + 1;
    end
  end

  // Issues one request and reports latency (cycles from accept to done), flags and write count.
  task automatic do_access(input logic st, input logic hf, input logic [7:0] a,
                           input logic [15:0] wd, input logic [11:0] pc,
                           output int lat, output logic dp, output logic er,
                           output logic [15:0] rd, output int nwr, output int base,
                           output logic done_after);
    @(negedge clk);
    is_store = st; is_half = hf; addr = a; wdata = wd; prog_ctr = pc; req = 1'b1;
    @(posedge clk);
    base = wr_cnt;
    #1 req = 1'b0;
    lat = 0; dp = 1'b0; er = 1'b0; rd = 16'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; dp = dup; er = err; rd = rdata;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
    nwr = wr_cnt - base;
  endtask

  task automatic test_reset;
    int base;
    reset = 1'b1; req = 1'b0; is_store = 1'b0; is_half = 1'b0;
    addr = 8'h0; wdata = 16'h0; prog_ctr = 12'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", ready); end
    total++; if ({done, dup, err, dm_wr_en} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {done, dup, err, dm_wr_en}); end
    total++; if ({rdata, dm_addr, dm_dat_in} !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {rdata, dm_addr, dm_dat_in}); end
    reset = 1'b0;
    @(negedge clk);
    is_store = 1'b1; is_half = 1'b1; addr = 8'h10; wdata = 16'h1234; prog_ctr = 12'h050; req = 1'b1;
    @(posedge clk);
    base = wr_cnt;
    #1 req = 1'b0;
    @(negedge clk);
    total++; if (dm_wr_en !== 1'b1 || dm_addr !== 8'h10) begin bad++; $display("FAIL midrst_acc0 got=%b/%h want=1/10", dm_wr_en, dm_addr); end
    reset = 1'b1;
    #1;
    total++; if ({dm_wr_en, ready, done} !== 3'b010) begin bad++; $display("FAIL midrst_async got=%b want=010", {dm_wr_en, ready, done}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL midrst_writes got=%0d want=0", wr_cnt - base); end
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b%b want=01", done, ready); end
  endtask

  task automatic test_half_wrap;
    int lat, nwr, base; logic dp, er, da; logic [15:0] rd;
    do_access(1'b1, 1'b1, 8'hFF, 16'hBEEF, 12'd3, lat, dp, er, rd, nwr, base, da);
    total++; if (lat !== 3) begin bad++; $display("FAIL hst_lat got=%0d want=3", lat); end
    total++; if (nwr !== 2) begin bad++; $display("FAIL hst_nwr got=%0d want=2", nwr); end
    total++; if ({wr_addr_log[base[7:0]], wr_data_log[base[7:0]]} !== 16'hFFEF) begin bad++; $display("FAIL hst_w0 got=%h want=ffef", {wr_addr_log[base[7:0]], wr_data_log[base[7:0]]}); end
    total++; if ({wr_addr_log[base[7:0]+8'd1], wr_data_log[base[7:0]+8'd1]} !== 16'h00BE) begin bad++; $display("FAIL hst_w1 got=%h want=00be", {wr_addr_log[base[7:0]+8'd1], wr_data_log[base[7:0]+8'd1]}); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL hst_done_pulse got=%0b want=0", da); end
    do_access(1'b0, 1'b1, 8'hFF, 16'h0000, 12'd4, lat, dp, er, rd, nwr, base, da);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL hld_rdata got=%h want=beef", rd); end
    total++; if (lat !== 3 || nwr !== 0) begin bad++; $display("FAIL hld_lat_nwr got=%0d/%0d want=3/0", lat, nwr); end
  endtask

  task automatic test_byte_roundtrip;
    int lat, nwr, base; logic dp, er, da; logic [15:0] rd;
    do_access(1'b1, 1'b0, 8'h20, 16'h00A5, 12'd1, lat, dp, er, rd, nwr, base, da);
    total++; if (lat !== 2) begin bad++; $display("FAIL bst_lat got=%0d want=2", lat); end
    total++; if (nwr !== 1 || {wr_addr_log[base[7:0]], wr_data_log[base[7:0]]} !== 16'h20A5) begin bad++; $display("FAIL bst_write got=%0d %h want=1 20a5", nwr, {wr_addr_log[base[7:0]], wr_data_log[base[7:0]]}); end
    total++; if (dp !== 1'b0) begin bad++; $display("FAIL bst_dup got=%0b want=0", dp); end
    do_access(1'b0, 1'b0, 8'h20, 16'hFFFF, 12'd2, lat, dp, er, rd, nwr, base, da);
    total++; if (rd !== 16'h00A5) begin bad++; $display("FAIL bld_rdata got=%h want=00a5", rd); end
    total++; if (lat !== 2 || nwr !== 0) begin bad++; $display("FAIL bld_lat_nwr got=%0d/%0d want=2/0", lat, nwr); end
    total++; if (rdata !== 16'h00A5) begin bad++; $display("FAIL bld_hold got=%h want=00a5", rdata); end
  endtask

  task automatic test_dup_guard;
    int lat, nwr, base; logic dp, er, da; logic [15:0] rd;
    do_access(1'b1, 1'b0, 8'h40, 16'h0077, 12'd7, lat, dp, er, rd, nwr, base, da);
    total++; if (nwr !== 1 || mem[8'h40] !== 8'h77) begin bad++; $display("FAIL dup_first got=%0d %h want=1 77", nwr, mem[8'h40]); end
    do_access(1'b1, 1'b0, 8'h40, 16'h0011, 12'd7, lat, dp, er, rd, nwr, base, da);
    total++; if (lat !== 1 || dp !== 1'b1) begin bad++; $display("FAIL dup_second got=%0d/%0b want=1/1", lat, dp); end
    total++; if (nwr !== 0 || mem[8'h40] !== 8'h77) begin bad++; $display("FAIL dup_nowrite got=%0d %h want=0 77", nwr, mem[8'h40]); end
    total++; if (rdata !== 16'h00A5) begin bad++; $display("FAIL dup_rdata got=%h want=00a5", rdata); end
    do_access(1'b1, 1'b0, 8'h40, 16'h0011, 12'd8, lat, dp, er, rd, nwr, base, da);
    total++; if (lat !== 2 || dp !== 1'b0 || nwr !== 1 || mem[8'h40] !== 8'h11) begin bad++; $display("FAIL dup_third got=%0d/%0b/%0d/%h want=2/0/1/11", lat, dp, nwr, mem[8'h40]); end
  endtask

  task automatic test_ignored_req;
    int base, dones;
    @(negedge clk);
    is_store = 1'b0; is_half = 1'b0; addr = 8'h20; wdata = 16'h0; prog_ctr = 12'd10; req = 1'b1;
    @(posedge clk);
    base = wr_cnt;
    dones = 0;
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ign_busy got=%0b want=0", ready); end
    is_store = 1'b1; addr = 8'h60; wdata = 16'h0099; prog_ctr = 12'd11; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
      req = 1'b0;
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL ign_dones got=%0d want=1", dones); end
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL ign_writes got=%0d want=0", wr_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int base, dones, dups;
    @(negedge clk);
    is_store = 1'b1; is_half = 1'b0; addr = 8'h50; wdata = 16'h0033; prog_ctr = 12'd9; req = 1'b1;
    @(posedge clk);
    base = wr_cnt;
    dones = 0; dups = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (dup) dups++;
      if (i == 4) req = 1'b0;
    end
    total++; if (dones !== 2 || dups !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d/%0d want=2/1", dones, dups); end
    total++; if (wr_cnt - base !== 1 || mem[8'h50] !== 8'h33) begin bad++; $display("FAIL b2b_writes got=%0d %h want=1 33", wr_cnt - base, mem[8'h50]); end
  endtask

`ifdef LSU_MISALIGN_CHK_EN
  task automatic test_misalign;
    int lat, nwr, base; logic dp, er, da; logic [15:0] rd, before;
    before = rdata;
    do_access(1'b0, 1'b1, 8'h31, 16'h0, 12'd20, lat, dp, er, rd, nwr, base, da);
    total++; if (lat !== 1 || er !== 1'b1) begin bad++; $display("FAIL mis_err got=%0d/%0b want=1/1", lat, er); end
    total++; if (rd !== before || nwr !== 0) begin bad++; $display("FAIL mis_noacc got=%h/%0d want=%h/0", rd, nwr, before); end
  endtask
`endif

  initial begin
    test_reset;
    test_half_wrap;
    test_byte_roundtrip;
    test_dup_guard;
    test_ignored_req;
    test_back_to_back;
`ifdef LSU_MISALIGN_CHK_EN
    test_misalign;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls_access_ctrl.md
Name: ls_access_ctrl

Overview:
Initiator side of the data-memory port. Accepts load/store requests from the core datapath and sequences byte accesses into the 8-bit data memory. Multi-byte accesses are split into byte accesses, little-endian. Enforces at most one store per instruction by comparing program counters, so the memory side sees a clean single-cycle write enable.

Parameters:
AW, 8, data-memory address width (byte addressed, 2^AW deep)
PCW, 12, program-counter width used for the store-once guard

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
req  input  1  core request strobe, sampled only when ready=1
is_store  input  1  1=store, 0=load
is_half  input  1  1=16-bit access (two bytes), 0=byte access
addr  input  AW  byte address of the low byte
wdata  input  16  store data; only [7:0] used for byte stores
prog_ctr  input  PCW  PC of the issuing instruction
ready  output  1  high only in IDLE; request accepted on posedge when req&&ready
done  output  1  one-cycle pulse when the access completes
rdata  output  16  load result, valid while done=1 and held until next accept
dup  output  1  one-cycle pulse with done when a store was suppressed as a duplicate
err  output  1  misalignment flag (see Optional Feature); tied 0 when feature is off
dm_addr  output  AW  memory address
dm_wr_en  output  1  memory write enable
dm_dat_in  output  8  memory write data
dm_dat_out  input  8  memory read data (combinational from dm_addr)

Behaviour:
- States: IDLE, ACC0, ACC1, FIN.
- Reset (async): state=IDLE. ready=1; done=0, dup=0, err=0, dm_wr_en=0; rdata, dm_addr, dm_dat_in = 0; last_pc_vld=0, last_pc=0. No further memory writes after reset asserts, including mid-access.
- IDLE: on req&&ready, latch is_store, is_half, addr, wdata, prog_ctr. Go to ACC0, except for a duplicate store, which goes to FIN.
- Duplicate store: is_store && last_pc_vld && prog_ctr==last_pc. No write occurs and dup pulses with done.
- Every accepted store, duplicate or not, sets last_pc=prog_ctr and last_pc_vld=1. Loads do not touch the guard.
- ACC0:
  - dm_addr=addr.
  - Store: dm_wr_en=1, dm_dat_in=wdata[7:0] for exactly this cycle.
  - Load: rdata[7:0]<=dm_dat_out at the end of the cycle.
  - Next state is ACC1 if is_half, else FIN.
- ACC1:
  - dm_addr=addr+1, modulo 2^AW, so 0xFF wraps to 0x00.
  - Store: dm_wr_en=1, dm_dat_in=wdata[15:8].
  - Load: rdata[15:8]<=dm_dat_out.
  - Next state is FIN.
- FIN: done=1 for one cycle; next state is IDLE.
- Byte loads zero-extend: rdata[15:8]=0.
- Store does not modify rdata.
- Latency, counted from the accepting edge to the done cycle: byte access 2 cycles, half access 3 cycles, duplicate store 1 cycle.
- dm_wr_en is 0 in IDLE and FIN. dm_addr and dm_dat_in hold their last value outside ACC0/ACC1.
- Outputs are registered or decoded from registered state only. No combinational path exists from req to dm_wr_en.
- req while ready=0 is ignored, not queued.
- req held high across consecutive instructions: each acceptance in IDLE is a new access. A back-to-back store with an unchanged prog_ctr is suppressed as a duplicate.

Optional Feature:
Macro LSU_MISALIGN_CHK_EN.
- Defined: a half access with addr[0]=1 is flagged on acceptance. It goes to FIN with no memory access, err pulses with done, and rdata is unchanged.
- The flagged store still updates last_pc.
- Undefined: err is tied 0 and odd half accesses proceed with wrap-around as above.

Test Plan:
- Reset mid-operation: store half addr=0x10 accepted; assert reset during ACC0 -> dm_wr_en drops immediately, ready=1, done=0, and no write reaches 0x11.
- Byte round-trip: store byte addr=0x20 wdata=0x00A5 pc=1, then load byte addr=0x20 pc=2 -> store write 0xA5 in one cycle, done 2 cycles after accept; load rdata=0x00A5.
- Half with wrap: store half addr=0xFF wdata=0xBEEF pc=3 (feature off) -> writes 0xEF@0xFF then 0xBE@0x00; load half addr=0xFF returns 0xBEEF, done 3 cycles after accept.
- Duplicate guard: two accepted stores with pc=7 (second wdata=0x0011) -> second store produces no dm_wr_en, done and dup pulse 1 cycle after accept, and memory keeps the first value. A third store with pc=8 writes normally.
- Ignored request: pulse req while ready=0 -> no extra access and exactly one done per accepted request.
- Misalign (LSU_MISALIGN_CHK_EN defined): load half addr=0x31 -> err=1 and done=1 in the same cycle, no dm access, rdata unchanged.
